// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore control FSM for a shared-memory, shared-ALU multicycle ARM subset
//   datapath: DP reg/imm (ADD/SUB/AND/ORR), LDR, STR and B. Drives the
//   datapath selects and the unconditioned RegW/MemW/PCS strobes. The flag
//   condition check sits downstream and gates the strobes.
//
//   Optional feature macro: MCCTRL_CMP_EN
//     defined   : cmd=1010 with S=1 (CMP) is legal. It sets flags only and
//                 returns to FETCH straight from EXECR/EXECI.
//     undefined : cmd=1010 is reported as Illegal in DECODE.
//
//   Handshake: MemReady is a completion strobe. A memory access (FETCH,
//   MEMRD, MEMWR) completes in the cycle where MemReady=1. The FSM holds
//   that state and its address/strobe outputs until then. MemReady drives
//   only IRWrite/NextPC in FETCH and the next-state logic. No select
//   depends on it.
//
//   dbg_state exposes the current state encoding for checkers.
module multicycle_controller #(
  parameter int         STATE_W = 4,
  parameter logic [3:0] PC_REG  = 4'hF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic [3:0]         Rd,
  input  logic               MemReady,
  output logic               IRWrite,
  output logic               NextPC,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ALUControl,
  output logic [1:0]         FlagW,
  output logic               RegW,
  output logic               MemW,
  output logic               PCS,
  output logic               Illegal,
  output logic [STATE_W-1:0] dbg_state
);

  typedef enum logic [STATE_W-1:0] {
    s_fetch  = 0,
    s_decode = 1,
    s_memadr = 2,
    s_memrd  = 3,
    s_memwb  = 4,
    s_memwr  = 5,
    s_execr  = 6,
    s_execi  = 7,
    s_aluwb  = 8,
    s_branch = 9
  } state_t;

  state_t     state_q;
  state_t     state_next;

  logic [3:0] cmd;
  logic       s_bit;
  logic       cmd_add;
  logic       cmd_sub;
  logic       cmd_and;
  logic       cmd_orr;
  logic       cmd_cmp;
  logic       dp_legal;
  logic       enc_illegal;
  logic [1:0] alu_ctrl_dec;
  logic [1:0] flagw_dec;
  logic       branch;

  // IR field decode
  assign cmd     = Funct[4:1];
  assign s_bit   = Funct[0];
  assign cmd_add = (cmd == 4'b0100);
  assign cmd_sub = (cmd == 4'b0010);
  assign cmd_and = (cmd == 4'b0000);
  assign cmd_orr = (cmd == 4'b1100);
`ifdef MCCTRL_CMP_EN
  assign cmd_cmp = (cmd == 4'b1010) & s_bit;
`else
  assign cmd_cmp = 1'b0;
`endif
  assign dp_legal    = cmd_add | cmd_sub | cmd_and | cmd_orr | cmd_cmp;
  assign enc_illegal = (Op == 2'b11) | ((Op == 2'b00) & ~dp_legal);

  // Immediate and register-port selects follow the opcode directly
  assign ImmSrc    = Op;
  assign RegSrc    = {(Op == 2'b01), (Op == 2'b10)};
  assign dbg_state = state_q;

  // ALU operation and flag-write enables, used only in EXECR/EXECI
  always_comb begin
    alu_ctrl_dec = 2'b00;
    flagw_dec    = 2'b00;
    if (cmd_cmp) begin
      alu_ctrl_dec = 2'b01;
      flagw_dec    = 2'b11;
    end else begin
      if (cmd_sub)      alu_ctrl_dec = 2'b01;
      else if (cmd_and) alu_ctrl_dec = 2'b10;
      else if (cmd_orr) alu_ctrl_dec = 2'b11;
      flagw_dec = {s_bit, s_bit & (cmd_add | cmd_sub)};
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= s_fetch;
    else          state_q <= state_next;
  end

  // Next-state and per-state outputs; strobes are forced low during reset
  always_comb begin
    state_next = s_fetch;
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    FlagW      = 2'b00;
    RegW       = 1'b0;
    MemW       = 1'b0;
    Illegal    = 1'b0;
    branch     = 1'b0;
    PCS        = 1'b0;

    case (state_q)
      s_fetch: begin
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        IRWrite    = MemReady;
        NextPC     = MemReady;
        state_next = MemReady ? s_decode : s_fetch;
      end
      s_decode: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (enc_illegal) begin
          Illegal    = 1'b1;
          state_next = s_fetch;
        end else begin
          case (Op)
            2'b01:   state_next = s_memadr;
            2'b00:   state_next = Funct[5] ? s_execi : s_execr;
            2'b10:   state_next = s_branch;
            default: state_next = s_fetch;
          endcase
        end
      end
      s_memadr: begin
        ALUSrcB    = 2'b01;
        state_next = Funct[0] ? s_memrd : s_memwr;
      end
      s_memrd: begin
        AdrSrc     = 1'b1;
        state_next = MemReady ? s_memwb : s_memrd;
      end
      s_memwb: begin
        ResultSrc  = 2'b01;
        RegW       = 1'b1;
        state_next = s_fetch;
      end
      s_memwr: begin
        AdrSrc     = 1'b1;
        MemW       = 1'b1;
        state_next = MemReady ? s_fetch : s_memwr;
      end
      s_execr: begin
        ALUSrcB    = 2'b00;
        ALUControl = alu_ctrl_dec;
        FlagW      = flagw_dec;
        state_next = cmd_cmp ? s_fetch : s_aluwb;
      end
      s_execi: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_ctrl_dec;
        FlagW      = flagw_dec;
        state_next = cmd_cmp ? s_fetch : s_aluwb;
      end
      s_aluwb: begin
        ResultSrc  = 2'b00;
        RegW       = 1'b1;
        state_next = s_fetch;
      end
      s_branch: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch     = 1'b1;
        state_next = s_fetch;
      end
      default: state_next = s_fetch;
    endcase

    PCS = ((Rd == PC_REG) & RegW) | branch;

    if (!reset_n) begin
      IRWrite = 1'b0;
      NextPC  = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      PCS     = 1'b0;
      Illegal = 1'b0;
      FlagW   = 2'b00;
    end
  end

endmodule
